local_injector: RTL and testbench

Packetizing injector between a processing core and a router's local input port. Accepts a packet request (destination, length) plus a stream of 14-bit payload words. Emits one head flit and 1–4 body flits on the router's 17-bit local link, never exceeding the router's local buffer credit, which is signalled by the router's `local_full` output.

---
 rtl/noc_pkg.sv | 59 +++++
 rtl/local_injector_payload_fifo.sv | 54 +++++
 rtl/local_injector.sv | 127 ++++++++++++
 tb/tb_local_injector.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared flit format, type codes and injector state encoding for the local injector.
// Head flits are built from bit positions, body/tail flits from the flit_t view.
package noc_pkg;

    localparam int FLIT_W    = 17;
    localparam int PL_W      = 14;
    localparam int ID_W      = 4;
    localparam int LEN_W     = 2;

    localparam int VALID_BIT = 16;
    localparam int TYPE_LSB  = 14;
    localparam int DEST_LSB  = 10;
    localparam int SRC_LSB   = 6;
    localparam int LEN_LSB   = 4;

    typedef enum logic [1:0] {
        FLIT_NONE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_t;

    typedef struct packed {
        logic             valid;
        flit_type_t       ftype;
        logic [PL_W-1:0]  payload;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_BODY = 2'b10
    } inj_state_t;

    localparam flit_t IDLE_FLIT = '0;

    function automatic flit_t make_head(input logic [ID_W-1:0]  dest,
                                        input logic [ID_W-1:0]  src,
                                        input logic [LEN_W-1:0] len);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[VALID_BIT]             = 1'b1;
        f[TYPE_LSB +: 2]         = FLIT_HEAD;
        f[DEST_LSB +: ID_W]      = dest;
        f[SRC_LSB +: ID_W]       = src;
        f[LEN_LSB +: LEN_W]      = len;
        return flit_t'(f);
    endfunction

    function automatic flit_t make_body(input logic            last,
                                        input logic [PL_W-1:0] word);
        flit_t f;
        f.valid   = 1'b1;
        f.ftype   = last ? FLIT_TAIL : FLIT_BODY;
        f.payload = word;
        return f;
    endfunction

endpackage

// File: rtl/local_injector_payload_fifo.sv
// Synchronous payload FIFO; pointers carry one extra wrap bit so full and empty
// are distinguished without a separate occupancy counter.
module payload_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Guard both ports so a stray request can never corrupt the pointers.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/local_injector.sv
// Packetizes core requests and payload words into head/body/tail flits for a
// router local port, emitting a flit only in cycles where the router has credit.
module local_injector
    import noc_pkg::*;
#(
    parameter logic [ID_W-1:0] SRC_ID     = 4'd13,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ID_W-1:0]   req_dest_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              req_ready_o,
    input  logic              pl_valid_i,
    input  logic [PL_W-1:0]   pl_data_i,
    output logic              pl_ready_o,
    input  logic              local_full_i,
    output logic [FLIT_W-1:0] local_data_o,
    output logic              busy_o,
    output logic [7:0]        pkt_count_o
);

    // Handshake: a request transfers on a cycle with req_valid_i && req_ready_o,
    // a payload word on pl_valid_i && pl_ready_o; a flit transfers whenever
    // local_data_o[16] is set, which only happens while local_full_i is low.

    inj_state_t       state_q, state_d;
    logic [ID_W-1:0]  dest_q, dest_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       body_left_q, body_left_d;
    logic [7:0]       pkt_count_q, pkt_count_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [PL_W-1:0]  fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             tail_sent;
    logic             req_ready;
    flit_t            flit;

    assign fifo_push = pl_valid_i && !fifo_full;

    payload_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (pl_data_i),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            body_left_q <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            body_left_q <= body_left_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        body_left_d = body_left_q;
        req_ready   = 1'b0;
        fifo_pop    = 1'b0;
        tail_sent   = 1'b0;
        flit        = IDLE_FLIT;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid_i) begin
                    dest_d      = req_dest_i;
                    len_d       = req_len_i;
                    body_left_d = {1'b0, req_len_i} + 3'd1;
                    state_d     = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (!local_full_i) begin
                    flit    = make_head(dest_q, SRC_ID, len_q);
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                // A body flit needs both a buffered word and router credit.
                if (!fifo_empty && !local_full_i) begin
                    fifo_pop    = 1'b1;
                    flit        = make_body(body_left_q == 3'd1, fifo_head);
                    body_left_d = body_left_q - 3'd1;
                    if (body_left_q == 3'd1) begin
                        tail_sent = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pkt_count_d = pkt_count_q + {7'd0, tail_sent};
    end

    assign req_ready_o  = req_ready;
    assign pl_ready_o   = !fifo_full;
    assign local_data_o = flit;
    assign busy_o       = (state_q != ST_IDLE);
    assign pkt_count_o  = pkt_count_q;

endmodule

// File: tb/tb_local_injector.sv
// Bench for local_injector: a cycle table for the basic packet and credit stall,
// directed corner sequences, random traffic against a queue-based model.
module tb_local_injector;

    localparam logic [3:0] SRC   = 4'd13;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_dest = '0;
    logic [1:0]  req_len = '0;
    logic        req_ready_o;
    logic        pl_valid = 1'b0;
    logic [13:0] pl_data = '0;
    logic        pl_ready_o;
    logic        local_full = 1'b0;
    logic [16:0] local_data_o;
    logic        busy_o;
    logic [7:0]  pkt_count_o;

    always #5 clk = ~clk;

    local_injector #(
        .SRC_ID     (SRC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_dest_i   (req_dest),
        .req_len_i    (req_len),
        .req_ready_o  (req_ready_o),
        .pl_valid_i   (pl_valid),
        .pl_data_i    (pl_data),
        .pl_ready_o   (pl_ready_o),
        .local_full_i (local_full),
        .local_data_o (local_data_o),
        .busy_o       (busy_o),
        .pkt_count_o  (pkt_count_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int hs_cyc = 0;

    // Reference model: packet-level view of the injector.
    bit          m_busy;
    bit          m_head_pend;
    logic [3:0]  m_dest;
    logic [1:0]  m_len;
    int          m_left;
    int          m_tails;
    logic [13:0] exp_q[$];
    logic [16:0] seen_q[$];

    typedef struct {
        logic        req_valid;
        logic [3:0]  dest;
        logic [1:0]  len;
        logic        pl_valid;
        logic [13:0] pl_data;
        logic        full;
        logic [16:0] exp_data;
        logic        exp_rr;
        logic        exp_busy;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [16:0] head_flit(input logic [3:0] d, input logic [1:0] l);
        return (17'd1 << 16) | (17'd1 << 14) | (17'(d) << 10) | (17'(SRC) << 6) | (17'(l) << 4);
    endfunction

    function automatic logic [16:0] body_flit(input bit last, input logic [13:0] w);
        return (17'd1 << 16) | ((last ? 17'd3 : 17'd2) << 14) | 17'(w);
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_head_pend = 0;
        m_dest = '0;
        m_len = '0;
        m_left = 0;
        m_tails = 0;
        exp_q.delete();
    endtask

    // Called mid-cycle with inputs stable: compare, then advance the model.
    task automatic monitor();
        logic [16:0] exp_data;
        logic        exp_rr;
        logic        exp_plr;
        exp_data = '0;
        exp_rr   = !m_busy;
        exp_plr  = (exp_q.size() < DEPTH);
        if (m_busy && !local_full && m_head_pend)
            exp_data = head_flit(m_dest, m_len);
        else if (m_busy && !m_head_pend && !local_full && exp_q.size() > 0)
            exp_data = body_flit(m_left == 1, exp_q[0]);

        check("link", local_data_o, exp_data);
        check("credit_gate", local_full && local_data_o[16], 0);
        check("req_ready", req_ready_o, exp_rr);
        check("pl_ready", pl_ready_o, exp_plr);
        check("busy", busy_o, m_busy);
        check("pkt_count", pkt_count_o, m_tails % 256);
        if (local_data_o[16]) seen_q.push_back(local_data_o);

        if (exp_data[16]) begin
            if (m_head_pend) begin
                m_head_pend = 0;
            end else begin
                void'(exp_q.pop_front());
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_tails++;
                end
            end
        end
        if (pl_valid && exp_plr) exp_q.push_back(pl_data);
        if (req_valid && exp_rr) begin
            m_busy = 1;
            m_head_pend = 1;
            m_dest = req_dest;
            m_len = req_len;
            m_left = int'(req_len) + 1;
            hs_count++;
            hs_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        pl_valid = 1'b0;
        local_full = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, local_data_o, 0);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_pl_ready"}, pl_ready_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_count"}, pkt_count_o, 0);
    endtask

    task automatic push_word(input logic [13:0] w);
        pl_valid = 1'b1;
        pl_data = w;
        tick();
        pl_valid = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] d, input logic [1:0] l);
        int h;
        int n;
        h = hs_count;
        n = 0;
        req_valid = 1'b1;
        req_dest = d;
        req_len = l;
        while (hs_count == h && n < 50) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("req_timeout", n < 50, 1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy_o && n < limit) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, n < limit, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] w[5];
        int prev_hs;
        int done;
        int n;
        int h;

        //                req  dst   len  plv  pl_data  full exp_data   rr   busy cnt
        vecs[0]  = '{1'b0, 4'd0, 2'd0, 1'b1, 14'h0AA, 1'b0, 17'h00000, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 4'd0, 2'd0, 1'b1, 14'h155, 1'b0, 17'h00000, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 4'd5, 2'd1, 1'b0, 14'h000, 1'b0, 17'h00000, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b0, 17'h15750, 1'b0, 1'b1, 8'd0};
        vecs[4]  = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b0, 17'h180AA, 1'b0, 1'b1, 8'd0};
        vecs[5]  = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b0, 17'h1C155, 1'b0, 1'b1, 8'd0};
        vecs[6]  = '{1'b1, 4'd13, 2'd0, 1'b1, 14'h011, 1'b0, 17'h00000, 1'b1, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b1, 17'h00000, 1'b0, 1'b1, 8'd1};
        vecs[8]  = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b1, 17'h00000, 1'b0, 1'b1, 8'd1};
        vecs[9]  = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b1, 17'h00000, 1'b0, 1'b1, 8'd1};
        vecs[10] = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b0, 17'h17740, 1'b0, 1'b1, 8'd1};
        vecs[11] = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b1, 17'h00000, 1'b0, 1'b1, 8'd1};
        vecs[12] = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b0, 17'h1C011, 1'b0, 1'b1, 8'd1};
        vecs[13] = '{1'b0, 4'd0, 2'd0, 1'b0, 14'h000, 1'b0, 17'h00000, 1'b1, 1'b0, 8'd2};

        model_reset();
        do_reset();
        check_reset_values("reset");

        // Single packet, then a dest==SRC packet with head and tail credit stalls.
        for (int i = 0; i < 14; i++) begin
            req_valid  = vecs[i].req_valid;
            req_dest   = vecs[i].dest;
            req_len    = vecs[i].len;
            pl_valid   = vecs[i].pl_valid;
            pl_data    = vecs[i].pl_data;
            local_full = vecs[i].full;
            @(negedge clk);
            check($sformatf("vec%0d_data", i), local_data_o, vecs[i].exp_data);
            check($sformatf("vec%0d_req_ready", i), req_ready_o, vecs[i].exp_rr);
            check($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
            check($sformatf("vec%0d_count", i), pkt_count_o, vecs[i].exp_cnt);
            monitor();
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        pl_valid = 1'b0;
        local_full = 1'b0;

        // Payload starvation: len 3 with only two words available.
        seen_q.delete();
        push_word(14'($urandom_range(0, 16383)));
        push_word(14'($urandom_range(0, 16383)));
        send_req(4'($urandom_range(0, 15)), 2'd3);
        repeat (8) tick();
        check("t3_starve_busy", busy_o, 1);
        check("t3_starve_flits", seen_q.size(), 3);
        push_word(14'h3FFF);
        push_word(14'h0001);
        wait_idle("t3", 20);
        check("t3_flits", seen_q.size(), 5);
        if (seen_q.size() == 5) begin
            check("t3_body", seen_q[3], 17'h1BFFF);
            check("t3_tail", seen_q[4], 17'h1C001);
        end

        // FIFO full: five words offered, only four stored, drained in order.
        do_reset();
        seen_q.delete();
        for (int i = 0; i < 5; i++) begin
            w[i] = 14'($urandom_range(0, 16383));
            pl_valid = 1'b1;
            pl_data = w[i];
            tick();
            if (i == 3) check("t4_full", pl_ready_o, 0);
        end
        pl_valid = 1'b0;
        send_req(4'd2, 2'd3);
        wait_idle("t4", 20);
        check("t4_flits", seen_q.size(), 5);
        if (seen_q.size() == 5) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("t4_word%0d", k), seen_q[k+1], body_flit(k == 3, w[k]));
        end
        send_req(4'd6, 2'd0);
        repeat (4) tick();
        check("t4_empty_hold", busy_o, 1);
        push_word(14'h1234);
        wait_idle("t4b", 20);

        // Reset in the middle of a packet, then a fresh packet.
        do_reset();
        push_word(14'h0AAA);
        push_word(14'h0BBB);
        send_req(4'd3, 2'd1);
        tick();
        do_reset();
        check_reset_values("t5");
        seen_q.delete();
        push_word(14'h02A5);
        send_req(4'd7, 2'd0);
        wait_idle("t5", 20);
        check("t5_flits", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            check("t5_head", seen_q[0], 17'h15F40);
            check("t5_tail", seen_q[1], 17'h1C2A5);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            local_full = ($urandom_range(0, 3) == 0);
            pl_valid = $urandom_range(0, 1);
            pl_data = 14'($urandom_range(0, 16383));
            if (!req_valid && $urandom_range(0, 3) == 0) begin
                req_valid = 1'b1;
                req_dest = 4'($urandom_range(0, 15));
                req_len = 2'($urandom_range(0, 3));
            end
            h = hs_count;
            tick();
            if (hs_count != h) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        local_full = 1'b0;
        n = 0;
        while (busy_o && n < 200) begin
            pl_valid = 1'b1;
            pl_data = 14'($urandom_range(0, 16383));
            tick();
            n++;
        end
        pl_valid = 1'b0;
        check("rand_drain_timeout", n < 200, 1);

        // 256 back-to-back len-0 packets with a pre-filled FIFO.
        do_reset();
        pl_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pl_data = 14'($urandom_range(0, 16383));
            tick();
        end
        req_valid = 1'b1;
        req_len = 2'd0;
        req_dest = 4'($urandom_range(0, 15));
        done = 0;
        prev_hs = 0;
        n = 0;
        while (done < 256 && n < 2000) begin
            pl_data = 14'($urandom_range(0, 16383));
            h = hs_count;
            tick();
            n++;
            if (hs_count != h) begin
                if (done > 0) check("t6_period", hs_cyc - prev_hs, 3);
                prev_hs = hs_cyc;
                done++;
                req_dest = 4'($urandom_range(0, 15));
                if (done == 256) req_valid = 1'b0;
            end
        end
        check("t6_timeout", n < 2000, 1);
        wait_idle("t6", 20);
        pl_valid = 1'b0;
        check("t6_wrap", pkt_count_o, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
